// File: rtl/sha512_core_input_dispatch_pkg.sv
// Shared definitions for the sha512crypt core-array block loader: block-op field,
// loader FSM states and slot index helpers.
package sha512_core_input_dispatch_pkg;

    localparam int unsigned BLK_OP_MSB = 3;
    localparam int unsigned BLK_OP_W   = BLK_OP_MSB + 1;

    // Block-op field codes carried alongside every word of a block.
    localparam logic [BLK_OP_W-1:0] BLK_OP_NONE       = 4'h0;
    localparam logic [BLK_OP_W-1:0] BLK_OP_INIT       = 4'h1;
    localparam logic [BLK_OP_W-1:0] BLK_OP_UPDATE     = 4'h2;
    localparam logic [BLK_OP_W-1:0] BLK_OP_FINAL      = 4'h4;
    localparam logic [BLK_OP_W-1:0] BLK_OP_INIT_FINAL = 4'h5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StPad  = 2'd2
    } state_e;

    // Index width that stays legal when only one item exists.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Slot encoding: slot = core * n_ctx + ctx.
    function automatic int unsigned slot_core(input int unsigned slot, input int unsigned n_ctx);
        return slot / n_ctx;
    endfunction

    function automatic int unsigned slot_ctx(input int unsigned slot, input int unsigned n_ctx);
        return slot % n_ctx;
    endfunction

endpackage

// File: rtl/sha512_core_input_dispatch_slot_rr_arbiter.sv
// Round-robin slot picker: first requesting slot at or after ptr_i, wrapping.
module sha512_core_input_dispatch_slot_rr_arbiter
    import sha512_core_input_dispatch_pkg::*;
#(
    parameter int unsigned SLOTS   = 8,
    localparam int unsigned SLOT_W = idx_w(SLOTS)
) (
    input  logic [SLOTS-1:0]  req_i,
    input  logic [SLOT_W-1:0] ptr_i,
    output logic [SLOT_W-1:0] gnt_o,
    output logic              gnt_valid_o
);

    // Scan from the pointer and keep the first hit.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            idx = (32'(ptr_i) + i) % SLOTS;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_o       = SLOT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sha512_core_input_dispatch.sv
// Block loader for the sha512crypt core array: picks a free (core, ctx) slot,
// writes a 16-word block into it and signals input-ready with the last word.
module sha512_core_input_dispatch
    import sha512_core_input_dispatch_pkg::*;
#(
    parameter int unsigned N_CORES   = 4,
    parameter int unsigned N_CTX     = 2,
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned BLK_WORDS = 16,
    localparam int unsigned SLOTS    = N_CORES * N_CTX,
    localparam int unsigned SLOT_W   = idx_w(SLOTS),
    localparam int unsigned ADDR_W   = idx_w(BLK_WORDS),
    localparam int unsigned CTX_W    = idx_w(N_CTX)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                in_valid_i,
    input  logic [WORD_W-1:0]   in_data_i,
    input  logic                in_last_i,
    input  logic [BLK_OP_W-1:0] in_blk_op_i,
    input  logic                in_force_slot_i,
    input  logic [SLOT_W-1:0]   in_slot_i,
    output logic                in_ready_o,
    input  logic [SLOTS-1:0]    core_ready_i,
    output logic [N_CORES-1:0]  core_wr_en_o,
    output logic [WORD_W-1:0]   core_din_o,
    output logic [ADDR_W-1:0]   core_wr_addr_o,
    output logic [BLK_OP_W-1:0] core_blk_op_o,
    output logic [CTX_W-1:0]    core_input_ctx_o,
    output logic                core_input_seq_o,
    output logic [N_CORES-1:0]  core_set_input_ready_o,
    output logic                blk_done_o,
    output logic [SLOT_W-1:0]   blk_slot_o,
    output logic                err_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BLK_WORDS - 1);

    state_e state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                forced_q, forced_d;
    logic [BLK_OP_W-1:0] op_q, op_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [SLOT_W-1:0]   rr_q, rr_d;
    logic [SLOTS-1:0]    seq_q, seq_d;
    logic [SLOTS-1:0]    pend_q, pend_d;
    logic                err_q, err_d;

    logic [N_CORES-1:0]  wr_en_q, wr_en_d;
    logic [WORD_W-1:0]   din_q, din_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BLK_OP_W-1:0] blk_op_q, blk_op_d;
    logic [CTX_W-1:0]    ctx_q, ctx_d;
    logic                seq_out_q, seq_out_d;
    logic [N_CORES-1:0]  sir_q, sir_d;
    logic                done_q, done_d;
    logic [SLOT_W-1:0]   done_slot_q, done_slot_d;

    logic [SLOTS-1:0]    free;
    logic [SLOT_W-1:0]   rr_gnt;
    logic                rr_gnt_valid;
    logic                in_ready;
    logic                do_write;
    logic                end_blk;
    logic [WORD_W-1:0]   wdata;
    logic [N_CORES-1:0]  core_oh;

    // A slot stays pending from its block end until its ready bit has dropped.
    assign free = core_ready_i & ~pend_q;

    sha512_core_input_dispatch_slot_rr_arbiter #(
        .SLOTS(SLOTS)
    ) u_arb (
        .req_i      (free),
        .ptr_i      (rr_q),
        .gnt_o      (rr_gnt),
        .gnt_valid_o(rr_gnt_valid)
    );

    // Next-state logic: slot selection, word acceptance, padding and block end.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        forced_d    = forced_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        seq_d       = seq_q;
        pend_d      = pend_q & core_ready_i;
        err_d       = err_q;
        wr_en_d     = '0;
        din_d       = din_q;
        addr_d      = addr_q;
        blk_op_d    = blk_op_q;
        ctx_d       = ctx_q;
        seq_out_d   = seq_out_q;
        sir_d       = '0;
        done_d      = 1'b0;
        done_slot_d = '0;
        in_ready    = 1'b0;
        do_write    = 1'b0;
        end_blk     = 1'b0;
        wdata       = '0;
        core_oh     = N_CORES'(1) << slot_core(32'(slot_q), N_CTX);

        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    // A busy forced slot stalls; it never falls back to round-robin.
                    if (in_force_slot_i) begin
                        if (free[in_slot_i]) begin
                            slot_d   = in_slot_i;
                            forced_d = 1'b1;
                            op_d     = in_blk_op_i;
                            cnt_d    = '0;
                            state_d  = StLoad;
                        end
                    end else if (rr_gnt_valid) begin
                        slot_d   = rr_gnt;
                        forced_d = 1'b0;
                        op_d     = in_blk_op_i;
                        cnt_d    = '0;
                        state_d  = StLoad;
                    end
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid_i) begin
                    do_write = 1'b1;
                    wdata    = in_data_i;
                    if (cnt_q == LastAddr) begin
                        end_blk = 1'b1;
                        if (!in_last_i) err_d = 1'b1;
                    end else if (in_last_i) begin
                        err_d   = 1'b1;
                        state_d = StPad;
                    end
                end
            end
            StPad: begin
                do_write = 1'b1;
                if (cnt_q == LastAddr) end_blk = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (do_write) begin
            wr_en_d   = core_oh;
            din_d     = wdata;
            addr_d    = cnt_q;
            blk_op_d  = op_q;
            ctx_d     = CTX_W'(slot_ctx(32'(slot_q), N_CTX));
            seq_out_d = seq_q[slot_q];
            cnt_d     = cnt_q + ADDR_W'(1);
        end

        if (end_blk) begin
            sir_d          = core_oh;
            done_d         = 1'b1;
            done_slot_d    = slot_q;
            seq_d[slot_q]  = ~seq_q[slot_q];
            pend_d[slot_q] = 1'b1;
            if (!forced_q) begin
                if (32'(slot_q) == SLOTS - 1) rr_d = '0;
                else                          rr_d = slot_q + SLOT_W'(1);
            end
            cnt_d   = '0;
            state_d = StIdle;
        end
    end

    // State and registered outputs; reset abandons any block in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            forced_q    <= 1'b0;
            op_q        <= '0;
            cnt_q       <= '0;
            rr_q        <= '0;
            seq_q       <= '0;
            pend_q      <= '0;
            err_q       <= 1'b0;
            wr_en_q     <= '0;
            din_q       <= '0;
            addr_q      <= '0;
            blk_op_q    <= '0;
            ctx_q       <= '0;
            seq_out_q   <= 1'b0;
            sir_q       <= '0;
            done_q      <= 1'b0;
            done_slot_q <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            forced_q    <= forced_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            seq_q       <= seq_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            wr_en_q     <= wr_en_d;
            din_q       <= din_d;
            addr_q      <= addr_d;
            blk_op_q    <= blk_op_d;
            ctx_q       <= ctx_d;
            seq_out_q   <= seq_out_d;
            sir_q       <= sir_d;
            done_q      <= done_d;
            done_slot_q <= done_slot_d;
        end
    end

    assign in_ready_o             = in_ready;
    assign core_wr_en_o           = wr_en_q;
    assign core_din_o             = din_q;
    assign core_wr_addr_o         = addr_q;
    assign core_blk_op_o          = blk_op_q;
    assign core_input_ctx_o       = ctx_q;
    assign core_input_seq_o       = seq_out_q;
    assign core_set_input_ready_o = sir_q;
    assign blk_done_o             = done_q;
    assign blk_slot_o             = done_slot_q;
    assign err_o                  = err_q;

endmodule

// File: tb/tb_sha512_core_input_dispatch.sv
// Directed bench for the block loader with a write scoreboard.
module tb_sha512_core_input_dispatch;
    import sha512_core_input_dispatch_pkg::*;

    localparam int unsigned N_CORES = 4;
    localparam int unsigned N_CTX   = 2;
    localparam int unsigned SLOTS   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_last;
    logic [3:0]  in_blk_op;
    logic        in_force_slot;
    logic [2:0]  in_slot;
    logic        in_ready_o;
    logic [7:0]  core_ready;
    logic [3:0]  core_wr_en_o;
    logic [63:0] core_din_o;
    logic [3:0]  core_wr_addr_o;
    logic [3:0]  core_blk_op_o;
    logic        core_input_ctx_o;
    logic        core_input_seq_o;
    logic [3:0]  core_set_input_ready_o;
    logic        blk_done_o;
    logic [2:0]  blk_slot_o;
    logic        err_o;

    always #5 clk = ~clk;

    sha512_core_input_dispatch #(
        .N_CORES  (N_CORES),
        .N_CTX    (N_CTX),
        .WORD_W   (64),
        .BLK_WORDS(16)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset),
        .in_valid_i            (in_valid),
        .in_data_i             (in_data),
        .in_last_i             (in_last),
        .in_blk_op_i           (in_blk_op),
        .in_force_slot_i       (in_force_slot),
        .in_slot_i             (in_slot),
        .in_ready_o            (in_ready_o),
        .core_ready_i          (core_ready),
        .core_wr_en_o          (core_wr_en_o),
        .core_din_o            (core_din_o),
        .core_wr_addr_o        (core_wr_addr_o),
        .core_blk_op_o         (core_blk_op_o),
        .core_input_ctx_o      (core_input_ctx_o),
        .core_input_seq_o      (core_input_seq_o),
        .core_set_input_ready_o(core_set_input_ready_o),
        .blk_done_o            (blk_done_o),
        .blk_slot_o            (blk_slot_o),
        .err_o                 (err_o)
    );

    typedef struct packed {
        logic [3:0]  wr_en;
        logic [63:0] din;
        logic [3:0]  addr;
        logic [3:0]  op;
        logic        ctx;
        logic        seq;
        logic [3:0]  sir;
        logic        done;
        logic [2:0]  slot;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] blk_data [16];
    logic [7:0]  seq_m;
    int          st;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [87:0] all_outputs();
        return {in_ready_o, core_wr_en_o, core_set_input_ready_o, blk_done_o, blk_slot_o, err_o,
                core_din_o, core_wr_addr_o, core_blk_op_o, core_input_ctx_o, core_input_seq_o};
    endfunction

    task automatic gen_data();
        for (int w = 0; w < 16; w++) blk_data[w] = {32'($urandom), 32'($urandom)};
    endtask

    // Expected writes for the first n words of a block landing in slot s.
    task automatic push_block(input int s, input logic [3:0] op, input int last_at, input int n);
        exp_t e;
        for (int w = 0; w < n; w++) begin
            e.wr_en = 4'(1 << (s / N_CTX));
            e.din   = (w <= last_at) ? blk_data[w] : 64'h0;
            e.addr  = 4'(w);
            e.op    = op;
            e.ctx   = 1'(s % N_CTX);
            e.seq   = seq_m[s];
            e.sir   = (w == 15) ? e.wr_en : 4'h0;
            e.done  = (w == 15);
            e.slot  = (w == 15) ? 3'(s) : 3'h0;
            exp_q.push_back(e);
        end
        if (n == 16) seq_m[s] = ~seq_m[s];
    endtask

    task automatic drive_block(input int n_acc, input int last_at, input logic [3:0] op,
                               input logic frc, input logic [2:0] fslot, output int stalls);
        int waited;
        stalls = 0;
        for (int w = 0; w < n_acc; w++) begin
            in_valid      = 1'b1;
            in_data       = blk_data[w];
            in_last       = (w == last_at);
            in_blk_op     = op;
            in_force_slot = frc;
            in_slot       = fslot;
            waited        = 0;
            @(negedge clk);
            while (!in_ready_o && waited < 100) begin
                stalls++;
                waited++;
                @(negedge clk);
            end
            if (!in_ready_o) begin
                check("accept_timeout", 128'(in_ready_o), 128'(1));
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid      = 1'b0;
        in_last       = 1'b0;
        in_force_slot = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_last       = 1'b0;
        in_force_slot = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seq_m = '0;
        @(negedge clk);
        check("reset_outputs", 128'(all_outputs()), 128'(0));
        check("reset_sb_empty", 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        repeat (20) @(negedge clk);
        check(tag, 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write is matched against the oldest expected entry.
    always @(negedge clk) begin
        exp_t obs;
        exp_t e;
        obs = {core_wr_en_o, core_din_o, core_wr_addr_o, core_blk_op_o, core_input_ctx_o,
               core_input_seq_o, core_set_input_ready_o, blk_done_o, blk_slot_o};
        if (core_wr_en_o != 4'h0) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 128'(obs), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("block_write", 128'(obs), 128'(e));
            end
        end else begin
            check("idle_pulses", 128'({core_set_input_ready_o, blk_done_o, blk_slot_o}), 128'(0));
        end
    end

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        in_blk_op     = '0;
        in_force_slot = 1'b0;
        in_slot       = '0;
        core_ready    = 8'hFF;
        seq_m         = '0;

        // Single block, all free: slot 0, core 0, ctx 0, seq 0.
        do_reset();
        gen_data();
        push_block(0, BLK_OP_INIT, 15, 16);
        drive_block(16, 15, BLK_OP_INIT, 1'b0, 3'd0, st);
        drain("t1_drained");
        check("t1_err", 128'(err_o), 128'(0));

        // Four back-to-back blocks: slots 0..3, one IDLE cycle before each.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            gen_data();
            push_block(b, BLK_OP_UPDATE, 15, 16);
            drive_block(16, 15, BLK_OP_UPDATE, 1'b0, 3'd0, st);
            check($sformatf("t2_idle_cycles_blk%0d", b), 128'(st), 128'(1));
        end
        drain("t2_drained");

        // Only slot 2 ready; second block waits for ready[2] to drop and rise.
        do_reset();
        core_ready = 8'b0000_0100;
        gen_data();
        push_block(2, BLK_OP_UPDATE, 15, 16);
        drive_block(16, 15, BLK_OP_UPDATE, 1'b0, 3'd0, st);
        gen_data();
        push_block(2, BLK_OP_FINAL, 15, 16);
        in_valid  = 1'b1;
        in_data   = blk_data[0];
        in_blk_op = BLK_OP_FINAL;
        repeat (4) begin
            @(negedge clk);
            check("t3_stall", 128'(in_ready_o), 128'(0));
        end
        @(posedge clk);
        #1 core_ready = 8'b0000_0000;
        @(posedge clk);
        #1 core_ready = 8'b0000_0100;
        drive_block(16, 15, BLK_OP_FINAL, 1'b0, 3'd0, st);
        drain("t3_drained");

        // Forced slot 5 busy: stall despite other free slots, then core 2 ctx 1.
        do_reset();
        core_ready = 8'hDF;
        gen_data();
        push_block(5, BLK_OP_INIT_FINAL, 15, 16);
        in_valid      = 1'b1;
        in_data       = blk_data[0];
        in_blk_op     = BLK_OP_INIT_FINAL;
        in_force_slot = 1'b1;
        in_slot       = 3'd5;
        repeat (4) begin
            @(negedge clk);
            check("t4_forced_stall", 128'(in_ready_o), 128'(0));
        end
        @(posedge clk);
        #1 core_ready = 8'hFF;
        drive_block(16, 15, BLK_OP_INIT_FINAL, 1'b1, 3'd5, st);
        drain("t4_drained");
        // Forced dispatch leaves the round-robin pointer at 0.
        gen_data();
        push_block(0, BLK_OP_UPDATE, 15, 16);
        drive_block(16, 15, BLK_OP_UPDATE, 1'b0, 3'd0, st);
        drain("t4_rr_drained");

        // Short block: in_last on word 4, words 5..15 padded with zero.
        do_reset();
        gen_data();
        push_block(0, BLK_OP_UPDATE, 4, 16);
        drive_block(5, 4, BLK_OP_UPDATE, 1'b0, 3'd0, st);
        drain("t5_drained");
        check("t5_err_set", 128'(err_o), 128'(1));
        gen_data();
        push_block(1, BLK_OP_UPDATE, 15, 16);
        drive_block(16, 15, BLK_OP_UPDATE, 1'b0, 3'd0, st);
        drain("t5_next_drained");
        check("t5_err_sticky", 128'(err_o), 128'(1));

        // Reset on word 7: block abandoned, outputs clear, next block to slot 0.
        do_reset();
        gen_data();
        push_block(0, BLK_OP_INIT, 15, 7);
        drive_block(7, 15, BLK_OP_INIT, 1'b0, 3'd0, st);
        in_valid  = 1'b1;
        in_data   = blk_data[7];
        in_last   = 1'b0;
        in_blk_op = BLK_OP_INIT;
        @(negedge clk);
        check("t6_word7_ready", 128'(in_ready_o), 128'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_reset_outputs", 128'(all_outputs()), 128'(0));
        reset    = 1'b0;
        in_valid = 1'b0;
        seq_m    = '0;
        check("t6_sb_empty", 128'(exp_q.size()), 128'(0));
        gen_data();
        push_block(0, BLK_OP_INIT, 15, 16);
        drive_block(16, 15, BLK_OP_INIT, 1'b0, 3'd0, st);
        drain("t6_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
